uart_prog_loader: RTL and testbench

- Upstream feeder of the instruction ROM's write port.
- Receives a program image over a UART line (8N1), assembles little-endian 32-bit words, and emits one-cycle write strobes with word-aligned byte addresses starting at 0.
- Holds the core in reset until the image is fully loaded, then releases it.

---
 rtl/uart_prog_loader.sv | 209 ++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// UART (8N1) program loader: length-prefixed little-endian word stream into the instruction ROM write port.
// Optional trailing 8-bit checksum byte when UART_LOADER_CHECKSUM_EN is defined.
module uart_prog_loader #(
  parameter int CLK_FREQ       = 100000000,
  parameter int BAUD           = 115200,
  parameter int MEM_DEPTH      = 4096,
  parameter int TIMEOUT_CYCLES = 10000000
) (
  input  logic        clk_100MHz,
  input  logic        arst_n,
  input  logic        uart_rx_i,
  output logic        w_ena_o,
  output logic [31:0] w_addr_o,
  output logic [31:0] w_data_o,
  output logic        cpu_rst_n_o,
  output logic        load_busy_o,
  output logic        load_done_o,
  output logic        load_err_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_M1      = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] L_LEN  = 3'd0;
  localparam logic [2:0] L_DATA = 3'd1;
`ifdef UART_LOADER_CHECKSUM_EN
  localparam logic [2:0] L_CSUM = 3'd2;
`endif
  localparam logic [2:0] L_DONE = 3'd3;
  localparam logic [2:0] L_ERR  = 3'd4;

  logic             rx_sync_p0, rx_sync_p1, rx_prev_p2;
  logic [1:0]       rx_state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       rx_byte;
  logic             byte_vld, frame_err;

  logic [2:0]       l_state;
  logic [1:0]       byte_cnt;
  logic [23:0]      len_asm, data_asm;
  logic [31:0]      len_q, word_idx, gap_cnt;
  logic             started_q;
  logic [31:0]      len_word, data_word;
  logic             in_load;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]       csum_q;
`endif

  // Stage 0-2: two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk_100MHz) begin
    if (!arst_n) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
      rx_prev_p2 <= 1'b1;
    end else begin
      rx_sync_p0 <= uart_rx_i;
      rx_sync_p1 <= rx_sync_p0;
      rx_prev_p2 <= rx_sync_p1;
    end
  end

  // Bit-level receiver: start bit re-checked at mid-bit, then one sample per bit period
  always_ff @(posedge clk_100MHz) begin
    if (!arst_n) begin
      rx_state  <= RX_IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      rx_byte   <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          clk_cnt <= '0;
          if (rx_prev_p2 && !rx_sync_p1) rx_state <= RX_START;
        end
        RX_START: begin
          if (clk_cnt == CNT_W'(HALF_M1)) begin
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            rx_state <= rx_sync_p1 ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            clk_cnt <= '0;
            rx_byte <= {rx_sync_p1, rx_byte[7:1]};
            if (bit_cnt == 3'd7) rx_state <= RX_STOP;
            else                 bit_cnt  <= bit_cnt + 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            clk_cnt   <= '0;
            rx_state  <= RX_IDLE;
            byte_vld  <= rx_sync_p1;
            frame_err <= !rx_sync_p1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign len_word  = {rx_byte, len_asm};
  assign data_word = {rx_byte, data_asm};

`ifdef UART_LOADER_CHECKSUM_EN
  assign in_load = (l_state == L_LEN) || (l_state == L_DATA) || (l_state == L_CSUM);
`else
  assign in_load = (l_state == L_LEN) || (l_state == L_DATA);
`endif

  // Load sequencer: length word, data words, optional checksum; the timeout overrides the case
  always_ff @(posedge clk_100MHz) begin
    if (!arst_n) begin
      l_state   <= L_LEN;
      byte_cnt  <= '0;
      len_asm   <= '0;
      data_asm  <= '0;
      len_q     <= '0;
      word_idx  <= '0;
      gap_cnt   <= '0;
      started_q <= 1'b0;
      w_ena_o   <= 1'b0;
      w_addr_o  <= '0;
      w_data_o  <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      w_ena_o <= 1'b0;
      if (byte_vld && in_load) started_q <= 1'b1;
      case (l_state)
        L_LEN: begin
          if (frame_err) begin
            l_state <= L_ERR;
          end else if (byte_vld) begin
            len_asm  <= len_word[31:8];
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) begin
              len_q <= len_word;
              if (len_word == 32'd0)                l_state <= L_DONE;
              else if (len_word > 32'(MEM_DEPTH))   l_state <= L_ERR;
              else                                  l_state <= L_DATA;
            end
          end
        end
        L_DATA: begin
          if (frame_err) begin
            l_state <= L_ERR;
          end else if (byte_vld) begin
            data_asm <= data_word[31:8];
            byte_cnt <= byte_cnt + 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
            csum_q   <= csum_q + rx_byte;
`endif
            if (byte_cnt == 2'd3) begin
              w_ena_o  <= 1'b1;
              w_addr_o <= word_idx << 2;
              w_data_o <= data_word;
              word_idx <= word_idx + 32'd1;
              if (word_idx == len_q - 32'd1) begin
`ifdef UART_LOADER_CHECKSUM_EN
                l_state <= L_CSUM;
`else
                l_state <= L_DONE;
`endif
              end
            end
          end
        end
`ifdef UART_LOADER_CHECKSUM_EN
        L_CSUM: begin
          if (frame_err)     l_state <= L_ERR;
          else if (byte_vld) l_state <= (rx_byte == csum_q) ? L_DONE : L_ERR;
        end
`endif
        default: ;
      endcase
      if (load_busy_o && !byte_vld) begin
        if (gap_cnt == 32'(TIMEOUT_CYCLES - 1)) l_state <= L_ERR;
        else                                    gap_cnt <= gap_cnt + 32'd1;
      end else begin
        gap_cnt <= '0;
      end
    end
  end

  assign load_busy_o = started_q && in_load;
  assign load_done_o = (l_state == L_DONE);
  assign load_err_o  = (l_state == L_ERR);
  assign cpu_rst_n_o = load_done_o;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: table of byte streams with expected writes/status, plus reset, glitch, timeout and length-limit sequences.
module tb_uart_prog_loader;

  localparam int CPB = 16;

  logic        clk_100MHz = 1'b0;
  logic        arst_n;
  logic        uart_rx_i;
  logic        w_ena_o;
  logic [31:0] w_addr_o, w_data_o;
  logic        cpu_rst_n_o, load_busy_o, load_done_o, load_err_o;

  uart_prog_loader #(
    .CLK_FREQ(100000000), .BAUD(6250000), .MEM_DEPTH(4096), .TIMEOUT_CYCLES(2000)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .arst_n     (arst_n),
    .uart_rx_i  (uart_rx_i),
    .w_ena_o    (w_ena_o),
    .w_addr_o   (w_addr_o),
    .w_data_o   (w_data_o),
    .cpu_rst_n_o(cpu_rst_n_o),
    .load_busy_o(load_busy_o),
    .load_done_o(load_done_o),
    .load_err_o (load_err_o)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int          n_chk = 0;
  int          n_err = 0;
  int          wr_cnt = 0;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];

  always @(negedge clk_100MHz) begin
    if (w_ena_o === 1'b1) begin
      if (wr_cnt < 64) begin
        wr_addr[wr_cnt] = w_addr_o;
        wr_data[wr_cnt] = w_data_o;
      end
      wr_cnt = wr_cnt + 1;
    end
  end

  typedef struct {
    string        name;
    logic [127:0] bytes;
    int           nb;
    int           bad_idx;
    int           nw;
    logic [31:0]  a0, d0, a1, d1;
    logic         done, err;
  } vec_t;

  vec_t vecs [6];
  int   nvec;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    arst_n    = 1'b0;
    uart_rx_i = 1'b1;
    repeat (5) @(negedge clk_100MHz);
    arst_n = 1'b1;
    @(negedge clk_100MHz);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx_i = 1'b0;
    repeat (CPB) @(negedge clk_100MHz);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      repeat (CPB) @(negedge clk_100MHz);
    end
    uart_rx_i = stop;
    repeat (CPB) @(negedge clk_100MHz);
    uart_rx_i = 1'b1;
    repeat (2 * CPB) @(negedge clk_100MHz);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    vecs[0] = '{"two_words", 128'h02000000_13000000_93001000_B6000000,
`ifdef UART_LOADER_CHECKSUM_EN
                13,
`else
                12,
`endif
                -1, 2, 32'h0, 32'h00000013, 32'h4, 32'h00100093, 1'b1, 1'b0};
    vecs[1] = '{"zero_len", 128'h0, 4, -1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[2] = '{"over_len", 128'h01100000_00000000_00000000_00000000,
                4, -1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1};
    vecs[3] = '{"frame_err", 128'h01000000_AA000000_00000000_00000000,
                5, 4, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1};
    nvec = 4;
`ifdef UART_LOADER_CHECKSUM_EN
    vecs[4] = '{"csum_ok", 128'h01000000_01020304_0A000000_00000000,
                9, -1, 1, 32'h0, 32'h04030201, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[5] = '{"csum_bad", 128'h01000000_01020304_0B000000_00000000,
                9, -1, 1, 32'h0, 32'h04030201, 32'h0, 32'h0, 1'b0, 1'b1};
    nvec = 6;
`endif

    // Reset state and idle line
    do_reset();
    base = wr_cnt;
    chk("rst_w_ena", {31'b0, w_ena_o}, 32'h0);
    chk("rst_w_addr", w_addr_o, 32'h0);
    chk("rst_w_data", w_data_o, 32'h0);
    chk("rst_status", {28'b0, cpu_rst_n_o, load_busy_o, load_done_o, load_err_o}, 32'h0);
    repeat (1000) @(negedge clk_100MHz);
    chk("idle_writes", 32'(wr_cnt - base), 32'h0);
    chk("idle_status", {28'b0, cpu_rst_n_o, load_busy_o, load_done_o, load_err_o}, 32'h0);

    // Short low glitch must not start a byte
    uart_rx_i = 1'b0;
    repeat (3) @(negedge clk_100MHz);
    uart_rx_i = 1'b1;
    repeat (300) @(negedge clk_100MHz);
    chk("glitch_status", {28'b0, cpu_rst_n_o, load_busy_o, load_done_o, load_err_o}, 32'h0);

    for (int v = 0; v < nvec; v++) begin
      do_reset();
      base = wr_cnt;
      for (int i = 0; i < vecs[v].nb; i++)
        send_byte(vecs[v].bytes[127 - 8*i -: 8], (i != vecs[v].bad_idx));
      repeat (40) @(negedge clk_100MHz);
      chk({vecs[v].name, "_nwrites"}, 32'(wr_cnt - base), 32'(vecs[v].nw));
      if (vecs[v].nw > 0 && wr_cnt > base) begin
        chk({vecs[v].name, "_addr0"}, wr_addr[base], vecs[v].a0);
        chk({vecs[v].name, "_data0"}, wr_data[base], vecs[v].d0);
      end
      if (vecs[v].nw > 1 && wr_cnt > base + 1) begin
        chk({vecs[v].name, "_addr1"}, wr_addr[base+1], vecs[v].a1);
        chk({vecs[v].name, "_data1"}, wr_data[base+1], vecs[v].d1);
      end
      chk({vecs[v].name, "_status"}, {28'b0, cpu_rst_n_o, load_busy_o, load_done_o, load_err_o},
          {28'b0, vecs[v].done, 1'b0, vecs[v].done, vecs[v].err});
    end

    // Length exactly MEM_DEPTH is accepted
    do_reset();
    send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    repeat (20) @(negedge clk_100MHz);
    chk("maxlen_status", {28'b0, cpu_rst_n_o, load_busy_o, load_done_o, load_err_o}, 32'h4);

    // Timeout after partial word
    do_reset();
    base = wr_cnt;
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b1);
    repeat (100) @(negedge clk_100MHz);
    chk("tmo_busy", {28'b0, cpu_rst_n_o, load_busy_o, load_done_o, load_err_o}, 32'h4);
    repeat (1700) @(negedge clk_100MHz);
    chk("tmo_not_yet", {31'b0, load_err_o}, 32'h0);
    repeat (300) @(negedge clk_100MHz);
    chk("tmo_status", {28'b0, cpu_rst_n_o, load_busy_o, load_done_o, load_err_o}, 32'h1);
    chk("tmo_writes", 32'(wr_cnt - base), 32'h0);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    repeat (20) @(negedge clk_100MHz);
    chk("err_sticky", {28'b0, cpu_rst_n_o, load_busy_o, load_done_o, load_err_o}, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
